// File: rtl/pipe_pkg.sv
// pipe_pkg -- shared pipeline constants and types for the hazard/stall logic.
//   T_W             width of Tuse/Tnew fields
//   TNEVER          Tuse value meaning "operand never read"
//   MULT_CYCLES_DEF default MDU occupancy for mult/multu
//   DIV_CYCLES_DEF  default MDU occupancy for div/divu
//   CNT_W           width of the MDU occupancy down-counter
//   md_state_t      MDU tracker FSM states
package pipe_pkg;

  localparam int T_W = 2;
  localparam logic [T_W-1:0] TNEVER = 2'd3;

  localparam int MULT_CYCLES_DEF = 5;
  localparam int DIV_CYCLES_DEF  = 10;
  localparam int CNT_W           = 4;

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } md_state_t;

endpackage

// File: rtl/md_tracker.sv
// md_tracker -- tracks how long the multiply/divide unit stays occupied.
//   clk       clock, all state on posedge
//   reset     synchronous, active-high
//   start     one-cycle pulse: E-stage instruction launches the MDU
//   div       qualifies start: 1 = divide, 0 = multiply
//   busy      MDU occupied (includes the launch cycle itself)
//   state_dbg current FSM state, for observation only
module md_tracker
  import pipe_pkg::*;
#(
  parameter int MULT_CYCLES = MULT_CYCLES_DEF,
  parameter int DIV_CYCLES  = DIV_CYCLES_DEF
) (
  input  logic      clk,
  input  logic      reset,
  input  logic      start,
  input  logic      div,
  output logic      busy,
  output md_state_t state_dbg
);

  localparam logic [CNT_W-1:0] MULT_LOAD = CNT_W'(MULT_CYCLES - 1);
  localparam logic [CNT_W-1:0] DIV_LOAD  = CNT_W'(DIV_CYCLES - 1);

  md_state_t        state, state_next;
  logic [CNT_W-1:0] cnt, cnt_next;
  logic [CNT_W-1:0] load;

  assign load = div ? DIV_LOAD : MULT_LOAD;

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      state <= state_next;
      cnt   <= cnt_next;
    end
  end

  // cnt holds the number of BUSY cycles still to come after the current one.
  // The launch cycle is covered by start itself, so an N-cycle operation
  // spends N-1 cycles in BUSY and leaves on the edge where cnt reaches 0.
  // A start while already BUSY simply restarts the occupancy window.
  always_comb begin
    state_next = state;
    cnt_next   = cnt;
    if (start) begin
      cnt_next   = load;
      state_next = (load == '0) ? IDLE : BUSY;
    end else if (state == BUSY) begin
      cnt_next = (cnt == '0) ? '0 : cnt - 1'b1;
      if (cnt <= 1) state_next = IDLE;
    end
  end

  assign busy      = ~reset & ((state == BUSY) | start);
  assign state_dbg = state;

endmodule

// File: rtl/stall_ctrl.sv
// stall_ctrl -- D-stage stall decision for the 5-stage pipeline.
//   clk, reset            clock; synchronous active-high reset
//   d_rs, d_rt            D-stage source register numbers
//   d_tuse_rs, d_tuse_rt  cycles until D needs rs/rt (TNEVER = unused)
//   d_is_md               D instr is mult/div/mfhi/mflo/mthi/mtlo
//   e_wa, m_wa            destination register in E/M (0 = none)
//   e_tnew, m_tnew        cycles until E/M result can be forwarded
//   e_md_start, e_md_div  E instr launches the MDU (div=1: divide)
//   f_en, d_en            PC and F/D register enables (low while stalling)
//   e_flush               bubble into D/E while stalling
//   md_busy               MDU occupied
//   stall_cnt             saturating count of stalled cycles since reset
//   md_state              MDU tracker state, for observation only
module stall_ctrl
  import pipe_pkg::*;
#(
  parameter int MULT_CYCLES = MULT_CYCLES_DEF,
  parameter int DIV_CYCLES  = DIV_CYCLES_DEF
) (
  input  logic           clk,
  input  logic           reset,
  input  logic [4:0]     d_rs,
  input  logic [4:0]     d_rt,
  input  logic [T_W-1:0] d_tuse_rs,
  input  logic [T_W-1:0] d_tuse_rt,
  input  logic           d_is_md,
  input  logic [4:0]     e_wa,
  input  logic [4:0]     m_wa,
  input  logic [T_W-1:0] e_tnew,
  input  logic [T_W-1:0] m_tnew,
  input  logic           e_md_start,
  input  logic           e_md_div,
  output logic           f_en,
  output logic           d_en,
  output logic           e_flush,
  output logic           md_busy,
  output logic [31:0]    stall_cnt,
  output md_state_t      md_state
);

  logic stall_rs, stall_rt, stall_md, stall;

  md_tracker #(
    .MULT_CYCLES(MULT_CYCLES),
    .DIV_CYCLES (DIV_CYCLES)
  ) u_md_tracker (
    .clk      (clk),
    .reset    (reset),
    .start    (e_md_start),
    .div      (e_md_div),
    .busy     (md_busy),
    .state_dbg(md_state)
  );

  // A producer blocks the consumer only if its result arrives later than
  // the consumer needs it. $0 is hardwired, so it never creates a hazard.
  assign stall_rs = (d_rs != 5'd0) &&
                    (((d_rs == e_wa) && (d_tuse_rs < e_tnew)) ||
                     ((d_rs == m_wa) && (d_tuse_rs < m_tnew)));
  assign stall_rt = (d_rt != 5'd0) &&
                    (((d_rt == e_wa) && (d_tuse_rt < e_tnew)) ||
                     ((d_rt == m_wa) && (d_tuse_rt < m_tnew)));
  assign stall_md = d_is_md & md_busy;

  assign stall   = ~reset & (stall_rs | stall_rt | stall_md);
  assign f_en    = ~stall;
  assign d_en    = ~stall;
  assign e_flush = stall;

  always_ff @(posedge clk) begin
    if (reset) begin
      stall_cnt <= '0;
    end else if (stall && (stall_cnt != 32'hFFFF_FFFF)) begin
      stall_cnt <= stall_cnt + 32'd1;
    end
  end

endmodule

// File: tb/tb_stall_ctrl.sv
// tb_stall_ctrl -- directed self-checking bench for stall_ctrl.
module tb_stall_ctrl;
  import pipe_pkg::*;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset;
  logic [4:0]  d_rs, d_rt, e_wa, m_wa;
  logic [1:0]  d_tuse_rs, d_tuse_rt, e_tnew, m_tnew;
  logic        d_is_md, e_md_start, e_md_div;
  logic        f_en, d_en, e_flush, md_busy;
  logic [31:0] stall_cnt;
  md_state_t   md_state;

  int tests  = 0;
  int failed = 0;

  stall_ctrl dut (
    .clk       (clk),
    .reset     (reset),
    .d_rs      (d_rs),
    .d_rt      (d_rt),
    .d_tuse_rs (d_tuse_rs),
    .d_tuse_rt (d_tuse_rt),
    .d_is_md   (d_is_md),
    .e_wa      (e_wa),
    .m_wa      (m_wa),
    .e_tnew    (e_tnew),
    .m_tnew    (m_tnew),
    .e_md_start(e_md_start),
    .e_md_div  (e_md_div),
    .f_en      (f_en),
    .d_en      (d_en),
    .e_flush   (e_flush),
    .md_busy   (md_busy),
    .stall_cnt (stall_cnt),
    .md_state  (md_state)
  );

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic clear_inputs();
    d_rs = 5'd0; d_rt = 5'd0; d_tuse_rs = TNEVER; d_tuse_rt = TNEVER;
    d_is_md = 1'b0; e_wa = 5'd0; m_wa = 5'd0; e_tnew = 2'd0; m_tnew = 2'd0;
    e_md_start = 1'b0; e_md_div = 1'b0;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      failed++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // stall as seen on the three enable/flush outputs together
  task automatic chk_stall(input string tag, input logic exp);
    chk({tag, ".f_en"},    {31'd0, f_en},    {31'd0, ~exp});
    chk({tag, ".d_en"},    {31'd0, d_en},    {31'd0, ~exp});
    chk({tag, ".e_flush"}, {31'd0, e_flush}, {31'd0, exp});
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    clear_inputs();
    reset = 1'b1;
    // hazards and an MDU launch present during reset must all be masked
    d_rs = 5'd1; e_wa = 5'd1; e_tnew = 2'd2; d_tuse_rs = 2'd0;
    d_is_md = 1'b1; e_md_start = 1'b1; e_md_div = 1'b1;
    tick(); tick();
    chk_stall("rst_mask", 1'b0);
    chk("rst_md_busy", {31'd0, md_busy}, 32'd0);
    chk("rst_cnt", stall_cnt, 32'd0);
    chk("rst_state", {31'd0, md_state}, {31'd0, IDLE});

    reset = 1'b0;
    clear_inputs();
    settle();
    chk_stall("idle", 1'b0);

    // load-use: lw $1 in E (tnew=2), add in D needs $1 next cycle
    d_rs = 5'd1; d_tuse_rs = 2'd1; e_wa = 5'd1; e_tnew = 2'd2;
    settle();
    chk_stall("lw_use", 1'b1);
    tick();
    e_wa = 5'd0; e_tnew = 2'd0; m_wa = 5'd1; m_tnew = 2'd1;
    settle();
    chk_stall("lw_use_after", 1'b0);
    chk("lw_use_cnt", stall_cnt, 32'd1);

    // rt hazard against M
    clear_inputs();
    d_rt = 5'd5; d_tuse_rt = 2'd0; m_wa = 5'd5; m_tnew = 2'd1;
    settle();
    chk_stall("rt_m_hazard", 1'b1);
    tick();
    clear_inputs();
    settle();
    chk("rt_m_cnt", stall_cnt, 32'd2);

    // tuse == tnew is satisfied by forwarding
    d_rt = 5'd5; d_tuse_rt = 2'd2; e_wa = 5'd5; e_tnew = 2'd2;
    settle();
    chk_stall("tuse_eq_tnew", 1'b0);
    // operand never used
    d_tuse_rt = TNEVER;
    settle();
    chk_stall("tuse_never", 1'b0);

    // register 0 exemption
    clear_inputs();
    d_rs = 5'd0; e_wa = 5'd0; e_tnew = 2'd2; d_tuse_rs = 2'd0;
    settle();
    chk_stall("r0_exempt", 1'b0);
    for (int i = 0; i < 4; i++) begin
      d_rt = 5'd0; d_tuse_rt = 2'd0; m_wa = 5'd0;
      e_tnew = 2'($urandom_range(0, 3));
      m_tnew = 2'($urandom_range(0, 3));
      settle();
      chk_stall("r0_rand", 1'b0);
    end
    clear_inputs();
    tick();

    // div launched, mflo held in D: stalls exactly 10 cycles
    e_md_start = 1'b1; e_md_div = 1'b1; d_is_md = 1'b1;
    settle();
    chk_stall("div_c0", 1'b1);
    chk("div_busy_c0", {31'd0, md_busy}, 32'd1);
    for (int k = 1; k < 10; k++) begin
      tick();
      e_md_start = 1'b0;
      settle();
      chk_stall("div_ck", 1'b1);
      if (k == 1) chk("div_state_busy", {31'd0, md_state}, {31'd0, BUSY});
    end
    tick();
    settle();
    chk_stall("div_done", 1'b0);
    chk("div_busy_done", {31'd0, md_busy}, 32'd0);
    chk("div_state_done", {31'd0, md_state}, {31'd0, IDLE});
    chk("div_cnt", stall_cnt, 32'd12);

    // mult with an unrelated instr in D: busy 5 cycles, no stall
    clear_inputs();
    e_md_start = 1'b1; e_md_div = 1'b0;
    settle();
    for (int k = 0; k < 5; k++) begin
      if (k > 0) begin
        tick();
        e_md_start = 1'b0;
        settle();
      end
      chk("mult_busy", {31'd0, md_busy}, 32'd1);
      chk_stall("mult_nostall", 1'b0);
    end
    tick();
    settle();
    chk("mult_busy_done", {31'd0, md_busy}, 32'd0);
    chk("mult_cnt", stall_cnt, 32'd12);

    // relaunch while busy: mult, then div two cycles later restarts window
    e_md_start = 1'b1; e_md_div = 1'b0;
    tick();
    e_md_start = 1'b0;
    tick();
    e_md_start = 1'b1; e_md_div = 1'b1;
    for (int k = 1; k < 10; k++) begin
      tick();
      e_md_start = 1'b0;
    end
    settle();
    chk("reload_busy_c9", {31'd0, md_busy}, 32'd1);
    tick();
    settle();
    chk("reload_busy_c10", {31'd0, md_busy}, 32'd0);

    // data hazard and MDU hazard together count once per cycle
    d_is_md = 1'b1; e_md_start = 1'b1; e_md_div = 1'b0;
    d_rs = 5'd1; e_wa = 5'd1; e_tnew = 2'd2; d_tuse_rs = 2'd0;
    settle();
    chk_stall("both_c0", 1'b1);
    tick();
    e_md_start = 1'b0; d_rs = 5'd0; e_wa = 5'd0; e_tnew = 2'd0;
    for (int k = 1; k < 5; k++) tick();
    settle();
    chk_stall("both_done", 1'b0);
    chk("both_cnt", stall_cnt, 32'd17);

    // reset three cycles into a div, mflo in D
    e_md_start = 1'b1; e_md_div = 1'b1; d_is_md = 1'b1;
    tick();
    e_md_start = 1'b0;
    tick(); tick();
    reset = 1'b1;
    settle();
    chk_stall("rst_mid_div", 1'b0);
    chk("rst_mid_busy", {31'd0, md_busy}, 32'd0);
    tick();
    reset = 1'b0;
    settle();
    chk("rst_mid_state", {31'd0, md_state}, {31'd0, IDLE});
    chk("rst_mid_busy_after", {31'd0, md_busy}, 32'd0);
    chk("rst_mid_cnt", stall_cnt, 32'd0);
    chk_stall("rst_mid_after", 1'b0);

    // saturation: preload near the top, then hold a stall
    clear_inputs();
    force dut.stall_cnt = 32'hFFFF_FFFD;
    settle();
    release dut.stall_cnt;
    settle();
    chk("sat_preload", stall_cnt, 32'hFFFF_FFFD);
    d_rs = 5'd1; e_wa = 5'd1; e_tnew = 2'd2; d_tuse_rs = 2'd0;
    tick();
    chk("sat_fffe", stall_cnt, 32'hFFFF_FFFE);
    tick();
    chk("sat_ffff", stall_cnt, 32'hFFFF_FFFF);
    tick();
    chk("sat_hold1", stall_cnt, 32'hFFFF_FFFF);
    tick();
    chk("sat_hold2", stall_cnt, 32'hFFFF_FFFF);

    // ---------------- report ----------------
    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

endmodule
